// File: rtl/updn_step_ctrl.sv
// rtl/updn_step_ctrl.sv - button sync/debounce front-end producing step pulses and direction; optional auto-repeat under AUTO_REPEAT_EN
module updn_step_ctrl #(
    parameter int DB_CYCLES  = 4,
    parameter int RPT_DELAY  = 16,
    parameter int RPT_PERIOD = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up_i,
    input  logic btn_dn_i,
    output logic step_o,
    output logic up_dn_o,
    output logic locked_o
);

    localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;

    if (DB_CYCLES < 1 || RPT_DELAY < 1 || RPT_PERIOD < 1) begin : g_param_check
        $error("updn_step_ctrl: DB_CYCLES, RPT_DELAY and RPT_PERIOD must all be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HELD_UP = 2'd1,
        HELD_DN = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    // Bit 0 is the up button, bit 1 the down button throughout.
    logic [1:0]     r_sync1;
    logic [1:0]     r_sync2;
    logic [1:0]     r_db;
    logic [1:0]     r_db_d;
    logic [1:0]     r_rise;
    logic [DBW-1:0] r_cnt [2];

    state_t r_state;
    state_t w_next;
    logic   w_step;
    logic   w_dir;
    logic   r_step;
    logic   r_up_dn;
    logic   w_rpt_fire;

    logic w_db_up;
    logic w_db_dn;
    logic w_rise_up;
    logic w_rise_dn;

    assign w_db_up   = r_db[0];
    assign w_db_dn   = r_db[1];
    assign w_rise_up = r_rise[0];
    assign w_rise_dn = r_rise[1];

    // Synchronise, debounce and register a one-cycle rising edge per button
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db    <= '0;
            r_db_d  <= '0;
            r_rise  <= '0;
            for (int i = 0; i < 2; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= {btn_dn_i, btn_up_i};
            r_sync2 <= r_sync1;
            r_db_d  <= r_db;
            r_rise  <= r_db & ~r_db_d;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == DBW'(DB_CYCLES - 1)) begin
                    // The DB_CYCLES-th differing sample accepts the new level
                    r_cnt[i] <= '0;
                    r_db[i]  <= ~r_db[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + DBW'(1);
                end
            end
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int HW      = (RPT_MAX > 1) ? $clog2(RPT_MAX + 1) : 1;

    logic [HW-1:0] r_hold;
    logic          r_first;
    logic          w_held_stay;

    // Repeat only while staying in a held state; leaving it cancels at once
    assign w_held_stay = ((r_state == HELD_UP) || (r_state == HELD_DN)) && (w_next == r_state);
    assign w_rpt_fire  = w_held_stay &&
                         (r_first ? (r_hold == HW'(RPT_DELAY - 1)) : (r_hold == HW'(RPT_PERIOD - 1)));

    // Hold counter: first interval is RPT_DELAY, later ones RPT_PERIOD
    always_ff @(posedge clk) begin
        if (rst || !w_held_stay) begin
            r_hold  <= '0;
            r_first <= 1'b1;
        end else if (w_rpt_fire) begin
            r_hold  <= '0;
            r_first <= 1'b0;
        end else begin
            r_hold <= r_hold + HW'(1);
        end
    end
`else
    assign w_rpt_fire = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a press while the other button is held is a conflict
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_rise_up && w_rise_dn) begin
                    w_next = LOCKED;
                end else if (w_rise_up && !w_db_dn) begin
                    w_next = HELD_UP;
                end else if (w_rise_dn && !w_db_up) begin
                    w_next = HELD_DN;
                end else if (w_rise_up || w_rise_dn) begin
                    w_next = LOCKED;
                end
            end
            HELD_UP: begin
                if (!w_db_up) begin
                    w_next = w_db_dn ? LOCKED : IDLE;
                end
            end
            HELD_DN: begin
                if (!w_db_dn) begin
                    w_next = w_db_up ? LOCKED : IDLE;
                end
            end
            LOCKED: begin
                if (!w_db_up && !w_db_dn) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Output decode: step on entry to a held state, or on an auto-repeat tick
    always_comb begin
        w_step = 1'b0;
        w_dir  = 1'b1;
        case (r_state)
            IDLE: begin
                if (w_next == HELD_UP) begin
                    w_step = 1'b1;
                    w_dir  = 1'b1;
                end else if (w_next == HELD_DN) begin
                    w_step = 1'b1;
                    w_dir  = 1'b0;
                end
            end
            HELD_UP: begin
                w_step = w_rpt_fire;
                w_dir  = 1'b1;
            end
            HELD_DN: begin
                w_step = w_rpt_fire;
                w_dir  = 1'b0;
            end
            default: begin
                w_step = 1'b0;
                w_dir  = 1'b1;
            end
        endcase
    end

    // Registered outputs; direction only moves together with a step
    always_ff @(posedge clk) begin
        if (rst) begin
            r_step  <= 1'b0;
            r_up_dn <= 1'b1;
        end else begin
            r_step <= w_step;
            if (w_step) begin
                r_up_dn <= w_dir;
            end
        end
    end

    assign step_o   = r_step;
    assign up_dn_o  = r_up_dn;
    assign locked_o = (r_state == LOCKED);

endmodule

// File: tb/tb_updn_step_ctrl.sv
// tb/tb_updn_step_ctrl.sv - directed self-checking bench for updn_step_ctrl
module tb_updn_step_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_up_i = 1'b0;
    logic btn_dn_i = 1'b0;
    logic step_o;
    logic up_dn_o;
    logic locked_o;

    int n_cmp = 0;
    int n_bad = 0;
    int t = 0;
    int consec = 0;
    logic prev_step = 1'b0;
    int q_edge[$];
    int q_dir[$];

    updn_step_ctrl #(.DB_CYCLES(4), .RPT_DELAY(16), .RPT_PERIOD(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_up_i (btn_up_i),
        .btn_dn_i (btn_dn_i),
        .step_o   (step_o),
        .up_dn_o  (up_dn_o),
        .locked_o (locked_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n clock edges, sampling 1 time unit after each edge
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (step_o === 1'b1) begin
                q_edge.push_back(t);
                q_dir.push_back(int'(up_dn_o));
                if (prev_step) consec++;
            end
            prev_step = (step_o === 1'b1);
            t++;
        end
    endtask

    task automatic mark();
        t = 0;
        q_edge.delete();
        q_dir.delete();
    endtask

    task automatic pulse_reset();
        btn_up_i = 1'b0;
        btn_dn_i = 1'b0;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    function automatic int edge_at(input int k);
        return (q_edge.size() > k) ? q_edge[k] : -1;
    endfunction

    function automatic int dir_at(input int k);
        return (q_dir.size() > k) ? q_dir[k] : -1;
    endfunction

    int unlock_edge;
`ifdef AUTO_REPEAT_EN
    int exp_rpt[6] = '{7, 23, 31, 39, 47, 55};
`endif

    initial begin
        // Reset state held for 3 cycles and after release
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("rst_step", step_o, 0);
            chk("rst_updn", up_dn_o, 1);
            chk("rst_lock", locked_o, 0);
        end
        rst = 1'b0;
        tick(1);
        chk("post_rst_step", step_o, 0);
        chk("post_rst_updn", up_dn_o, 1);
        chk("post_rst_lock", locked_o, 0);

`ifndef AUTO_REPEAT_EN
        // Up held 40 cycles: a single step at edge 7
        mark();
        btn_up_i = 1'b1;
        tick(40);
        chk("up_cnt", q_edge.size(), 1);
        chk("up_edge", edge_at(0), 7);
        chk("up_dir", dir_at(0), 1);
        btn_up_i = 1'b0;
        mark();
        tick(20);
        chk("up_rel_cnt", q_edge.size(), 0);
        chk("up_rel_dir", up_dn_o, 1);
`else
        // Up held 50 cycles with auto-repeat
        mark();
        btn_up_i = 1'b1;
        tick(50);
        btn_up_i = 1'b0;
        tick(20);
        chk("rpt_cnt", q_edge.size(), 6);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("rpt_edge%0d", k), edge_at(k), exp_rpt[k]);
            chk($sformatf("rpt_dir%0d", k), dir_at(k), 1);
        end
        // Reset just before the first repeat cancels it
        pulse_reset();
        mark();
        btn_up_i = 1'b1;
        tick(23);
        rst = 1'b1;
        tick(1);
        chk("rpt_rst_step", step_o, 0);
        chk("rpt_rst_cnt", q_edge.size(), 1);
        rst = 1'b0;
`endif

        // Down button bounces 1,0 then settles high at edge 2
        pulse_reset();
        mark();
        btn_dn_i = 1'b1;
        tick(1);
        btn_dn_i = 1'b0;
        tick(1);
        btn_dn_i = 1'b1;
        tick(14);
        btn_dn_i = 1'b0;
        tick(20);
        chk("dn_cnt", q_edge.size(), 1);
        chk("dn_edge", edge_at(0), 9);
        chk("dn_dir", dir_at(0), 0);
        chk("dn_hold_dir", up_dn_o, 0);

        // Both pressed on the same edge -> locked, no step
        pulse_reset();
        mark();
        btn_up_i = 1'b1;
        btn_dn_i = 1'b1;
        tick(7);
        chk("both_lock_pre", locked_o, 0);
        tick(3);
        chk("both_lock", locked_o, 1);
        btn_up_i = 1'b0;
        tick(12);
        chk("both_uprel_lock", locked_o, 1);
        chk("both_cnt", q_edge.size(), 0);
        btn_dn_i = 1'b0;
        mark();
        unlock_edge = -1;
        for (int i = 0; i < 20 && unlock_edge < 0; i++) begin
            tick(1);
            if (locked_o === 1'b0) unlock_edge = t - 1;
        end
        chk("both_unlock_edge", unlock_edge, 6);
        tick(10);
        chk("both_unlock_cnt", q_edge.size(), 0);

        // Up held, dn pressed, up released with dn held -> locked, no down step
        pulse_reset();
        mark();
        btn_up_i = 1'b1;
        tick(10);
        btn_dn_i = 1'b1;
        tick(2);
        btn_up_i = 1'b0;
        tick(15);
        chk("cross_cnt", q_edge.size(), 1);
        chk("cross_edge", edge_at(0), 7);
        chk("cross_dir", dir_at(0), 1);
        chk("cross_lock", locked_o, 1);
        btn_dn_i = 1'b0;
        mark();
        tick(15);
        chk("cross_unlock", locked_o, 0);
        chk("cross_rel_cnt", q_edge.size(), 0);

        // Reset wins over a pending step; a held button then steps afresh
        pulse_reset();
        mark();
        btn_dn_i = 1'b1;
        tick(7);
        chk("pend_cnt", q_edge.size(), 0);
        rst = 1'b1;
        tick(1);
        chk("pend_rst_step", step_o, 0);
        tick(1);
        rst = 1'b0;
        mark();
        tick(20);
        chk("fresh_cnt", q_edge.size(), 1);
        chk("fresh_edge", edge_at(0), 7);
        chk("fresh_dir", dir_at(0), 0);
        rst = 1'b1;
        tick(1);
        chk("midrst_step", step_o, 0);
        chk("midrst_updn", up_dn_o, 1);
        chk("midrst_lock", locked_o, 0);
        rst = 1'b0;
        btn_dn_i = 1'b0;
        tick(2);

        chk("no_consec_steps", consec, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
